// File: rtl/settings_ctrl.sv
// Paint-tool settings controller: button pulses edit a staged copy of
// tool/size/color, which is committed on the final select or dropped on cancel/timeout.
module settings_ctrl #(
  parameter int TIMEOUT   = 100_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_cancel,
  output logic       tool_on,
  output logic       size_sel,
  output logic [2:0] color,
  output logic       disp_tool,
  output logic       disp_size,
  output logic [2:0] disp_color,
  output logic [1:0] edit_field,
  output logic       blink,
  output logic       commit
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ED_TOOL  = 2'd1;
  localparam logic [1:0] S_ED_SIZE  = 2'd2;
  localparam logic [1:0] S_ED_COLOR = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          com_tool_q, com_tool_d, com_size_q, com_size_d;
  logic [2:0]    com_color_q, com_color_d;
  logic          stg_tool_q, stg_tool_d, stg_size_q, stg_size_d;
  logic [2:0]    stg_color_q, stg_color_d;
  logic          commit_q, commit_d;
  logic          blink_q, blink_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  always_comb begin
    state_d     = state_q;
    com_tool_d  = com_tool_q;
    com_size_d  = com_size_q;
    com_color_d = com_color_q;
    stg_tool_d  = stg_tool_q;
    stg_size_d  = stg_size_q;
    stg_color_d = stg_color_q;
    commit_d    = 1'b0;
    blink_d     = blink_q;
    tcnt_d      = tcnt_q;
    bcnt_d      = bcnt_q;

    if (state_q == S_IDLE) begin
      stg_tool_d  = com_tool_q;
      stg_size_d  = com_size_q;
      stg_color_d = com_color_q;
      tcnt_d      = '0;
      bcnt_d      = '0;
      blink_d     = 1'b0;
      if (btn_sel) begin
        state_d = S_ED_TOOL;
        blink_d = 1'b1;
      end
    end else begin
      tcnt_d = tcnt_q + 1'b1;
      // Divider keeps running across field advances so the blink phase is continuous.
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end

      if (btn_cancel) begin
        state_d = S_IDLE;
      end else if (btn_sel) begin
        tcnt_d = '0;
        if (state_q == S_ED_COLOR) begin
          com_tool_d  = stg_tool_q;
          com_size_d  = stg_size_q;
          com_color_d = stg_color_q;
          commit_d    = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = state_q + 2'd1;
        end
      end else if (btn_up || btn_down) begin
        tcnt_d = '0;
        if (btn_up != btn_down) begin
          case (state_q)
            S_ED_TOOL: stg_tool_d  = ~stg_tool_q;
            S_ED_SIZE: stg_size_d  = ~stg_size_q;
            default:   stg_color_d = btn_up ? stg_color_q + 3'd1 : stg_color_q - 3'd1;
          endcase
        end
      end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
      end

      if (state_d == S_IDLE) begin
        // Drop uncommitted edits; after a commit these equal the staged values anyway.
        stg_tool_d  = com_tool_d;
        stg_size_d  = com_size_d;
        stg_color_d = com_color_d;
        tcnt_d      = '0;
        bcnt_d      = '0;
        blink_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      com_tool_q  <= 1'b0;
      com_size_q  <= 1'b0;
      com_color_q <= 3'd0;
      stg_tool_q  <= 1'b0;
      stg_size_q  <= 1'b0;
      stg_color_q <= 3'd0;
      commit_q    <= 1'b0;
      blink_q     <= 1'b0;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      com_tool_q  <= com_tool_d;
      com_size_q  <= com_size_d;
      com_color_q <= com_color_d;
      stg_tool_q  <= stg_tool_d;
      stg_size_q  <= stg_size_d;
      stg_color_q <= stg_color_d;
      commit_q    <= commit_d;
      blink_q     <= blink_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign tool_on    = com_tool_q;
  assign size_sel   = com_size_q;
  assign color      = com_color_q;
  assign disp_tool  = stg_tool_q;
  assign disp_size  = stg_size_q;
  assign disp_color = stg_color_q;
  assign edit_field = state_q;
  assign blink      = blink_q;
  assign commit     = commit_q;
endmodule

// File: tb/tb_settings_ctrl.sv
// Bench for settings_ctrl: directed test-plan steps, then random button traffic,
// every cycle compared against a timestamp-based reference model.
module tb_settings_ctrl;
  localparam int TO = 8;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic clr = 1'b0, btn_sel = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_cancel = 1'b0;
  logic       tool_on, size_sel, disp_tool, disp_size, blink, commit;
  logic [2:0] color, disp_color;
  logic [1:0] edit_field;

  settings_ctrl #(.TIMEOUT(TO), .BLINK_DIV(BD)) dut (
    .clk(clk), .clr(clr), .btn_sel(btn_sel), .btn_up(btn_up), .btn_down(btn_down),
    .btn_cancel(btn_cancel), .tool_on(tool_on), .size_sel(size_sel), .color(color),
    .disp_tool(disp_tool), .disp_size(disp_size), .disp_color(disp_color),
    .edit_field(edit_field), .blink(blink), .commit(commit)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: field number, staged/committed values, and timestamps
  // (edge index of edit entry and of last activity) from which timeout and blink follow.
  int e = 0, mode = 0, entry = 0, last_act = 0;
  int c_tool = 0, c_size = 0, c_color = 0;
  int s_tool = 0, s_size = 0, s_color = 0;
  int m_commit = 0;

  task automatic model_edge(input bit s, input bit u, input bit d, input bit c, input bit r);
    e++;
    m_commit = 0;
    if (r) begin
      mode = 0; c_tool = 0; c_size = 0; c_color = 0;
      s_tool = 0; s_size = 0; s_color = 0;
    end else if (mode == 0) begin
      s_tool = c_tool; s_size = c_size; s_color = c_color;
      if (s) begin mode = 1; entry = e; last_act = e; end
    end else if (c) begin
      mode = 0;
    end else if (s) begin
      last_act = e;
      if (mode == 3) begin
        c_tool = s_tool; c_size = s_size; c_color = s_color;
        m_commit = 1; mode = 0;
      end else mode++;
    end else if (u || d) begin
      last_act = e;
      if (u != d) begin
        if (mode == 1) s_tool = 1 - s_tool;
        else if (mode == 2) s_size = 1 - s_size;
        else s_color = (s_color + (u ? 1 : 7)) % 8;
      end
    end else if (e - last_act == TO) begin
      mode = 0;
    end
    if (mode == 0) begin s_tool = c_tool; s_size = c_size; s_color = c_color; end
  endtask

  function automatic logic [15:0] model_vec();
    logic mb;
    mb = (mode != 0) && (((e - entry) / BD) % 2 == 0);
    return {2'b00, 1'(c_tool), 1'(c_size), 3'(c_color), 1'(s_tool), 1'(s_size),
            3'(s_color), 2'(mode), mb, 1'(m_commit)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {2'b00, tool_on, size_sel, color, disp_tool, disp_size, disp_color,
            edit_field, blink, commit};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit s, input bit u, input bit d, input bit c, input bit r);
    btn_sel = s; btn_up = u; btn_down = d; btn_cancel = c; clr = r;
    @(posedge clk);
    model_edge(s, u, d, c, r);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic p_sel();  step(1, 0, 0, 0, 0); endtask
  task automatic p_up();   step(0, 1, 0, 0, 0); endtask
  task automatic p_dn();   step(0, 0, 1, 0, 0); endtask
  task automatic p_idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset, then up presses in IDLE are ignored
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      p_up();
      chk("idle_zero", dut_vec(), 16'h0);
    end

    // Full edit and commit
    p_sel(); p_up(); p_sel(); p_dn(); p_sel();
    p_up(); p_up(); p_up();
    chk("staged_color", {13'd0, disp_color}, 16'd3);
    chk("committed_color_held", {13'd0, color}, 16'd0);
    p_sel();
    chk("commit", {9'd0, commit, tool_on, size_sel, color, edit_field},
        {9'd0, 1'b1, 1'b1, 1'b1, 3'd3, 2'd0});
    p_idle(1);
    chk("commit_single", {15'd0, commit}, 16'd0);

    // Color wrap from committed 0
    step(0, 0, 0, 0, 1);
    p_sel(); p_sel(); p_sel(); p_dn();
    chk("wrap_down", {13'd0, disp_color}, 16'd7);
    p_up(); p_up();
    chk("wrap_up", {13'd0, disp_color}, 16'd1);
    step(0, 0, 0, 1, 0);

    // Timeout after 8 idle cycles
    p_sel(); p_up();
    p_idle(7);
    chk("to_not_yet", {14'd0, edit_field}, 16'd1);
    p_idle(1);
    chk("to_fired", {12'd0, edit_field, disp_tool, tool_on}, 16'd0);
    // Pulse at the 8th cycle restarts the count
    p_sel(); p_up(); p_idle(7); p_up();
    chk("to_restart", {14'd0, edit_field}, 16'd1);
    p_idle(7);
    chk("to_restart_hold", {14'd0, edit_field}, 16'd1);
    p_idle(1);
    chk("to_restart_fire", {14'd0, edit_field}, 16'd0);

    // Cancel beats select in ED_COLOR; up+down in ED_TOOL does nothing
    p_sel(); p_sel(); p_sel();
    step(1, 0, 0, 1, 0);
    chk("cancel_sel", {13'd0, edit_field, commit}, 16'd0);
    p_sel();
    step(0, 1, 1, 0, 0);
    chk("updown", {14'd0, edit_field, disp_tool}, 16'd2);
    step(0, 0, 0, 1, 0);

    // Blink over a long edit, then reset in ED_SIZE after a commit
    p_sel(); p_up(); p_sel(); p_sel(); p_sel();
    chk("commit_tool", {15'd0, tool_on}, 16'd1);
    p_sel(); p_sel(); p_up();
    p_idle(5);
    step(0, 0, 0, 0, 1);
    chk("mid_reset", dut_vec(), 16'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
